// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared MIDI definitions for the byte-stream consumers:
//   msg_type_e     - decoded channel-voice message type (3 bits)
//   dec_state_e    - message assembler states
//   MIDI_* consts  - SysEx framing, real-time base and active-sense bytes
//   midi_data_len  - number of data bytes following a channel status byte
// -----------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [2:0] {
        MT_NONE     = 3'd0,
        MT_NOTE_OFF = 3'd1,
        MT_NOTE_ON  = 3'd2,
        MT_POLY_AT  = 3'd3,
        MT_CC       = 3'd4,
        MT_PROG     = 3'd5,
        MT_CHAN_AT  = 3'd6,
        MT_BEND     = 3'd7
    } msg_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_D1 = 3'd1,
        ST_WAIT_D2 = 3'd2,
        ST_SYSEX   = 3'd3,
        ST_DISCARD = 3'd4
    } dec_state_e;

    localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
    localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
    localparam logic [7:0] MIDI_RT_BASE     = 8'hF8;
    localparam logic [7:0] MIDI_ACTSENSE    = 8'hFE;

    // Program change (Cx) and channel pressure (Dx) carry one data byte,
    // every other channel-voice status carries two.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/midi_strobe_edge.sv
// -----------------------------------------------------------------------------
// midi_strobe_edge
// Registered rising-edge detector for a byte strobe that may stay high for
// several cycles. Produces exactly one accept pulse per strobe assertion.
// Ports:
//   clk    in  1  clock
//   strobe in  1  byte strobe from the upstream port
//   pulse  out 1  one-cycle accept pulse, high in the strobe's first high cycle
// -----------------------------------------------------------------------------
module midi_strobe_edge (
    input  logic clk,
    input  logic strobe,
    output logic pulse
);

    // Not reset on purpose: the copy keeps tracking the strobe through reset,
    // so a strobe already high when reset releases is not taken as a new byte.
    logic strobe_p0;

    always_ff @(posedge clk) begin
        strobe_p0 <= strobe;
    end

    assign pulse = strobe & ~strobe_p0;

endmodule

// File: rtl/midi_msg_decoder.sv
// -----------------------------------------------------------------------------
// midi_msg_decoder
// Assembles complete MIDI channel-voice messages from the CPU byte port.
// Handles running status, SysEx skipping and interleaved real-time bytes.
// Optional active-sense timeout: define MIDI_DEC_ACTSENSE_EN.
// Ports:
//   reg_clk        in  1  clock
//   reset_reg      in  1  synchronous active-high reset
//   byteready_c    in  1  byte strobe (1-3 cycles high per byte)
//   midi_in_data_c in  8  MIDI byte, stable while the strobe is high
//   cur_status_c   in  8  upstream logged status (informational only)
//   midibyte_nr_c  in  8  upstream byte counter (informational only)
//   msg_valid      out 1  one-cycle pulse, message present on msg_*
//   msg_type       out 3  msg_type_e
//   msg_chan       out 4  channel 0-15
//   msg_d1         out 7  first data byte
//   msg_d2         out 7  second data byte, 0 for one-data-byte messages
//   rt_valid       out 1  one-cycle pulse for a real-time byte
//   rt_code        out 3  low 3 bits of the real-time byte
//   sysex_active   out 1  high between F0 and F7
//   all_off        out 1  one-cycle pulse on active-sense timeout
// -----------------------------------------------------------------------------
module midi_msg_decoder
    import midi_pkg::*;
#(
    parameter bit         OMNI             = 1'b1,
    parameter logic [3:0] RX_CHANNEL       = 4'd0,
    parameter int         ACTSENSE_TIMEOUT = 15000000
) (
    input  logic       reg_clk,
    input  logic       reset_reg,
    input  logic       byteready_c,
    input  logic [7:0] midi_in_data_c,
    input  logic [7:0] cur_status_c,
    input  logic [7:0] midibyte_nr_c,
    output logic       msg_valid,
    output logic [2:0] msg_type,
    output logic [3:0] msg_chan,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2,
    output logic       rt_valid,
    output logic [2:0] rt_code,
    output logic       sysex_active,
    output logic       all_off
);

    // The decoder tracks its own status, so the upstream copies are not needed.
    logic unused_inputs;
    assign unused_inputs = ^{cur_status_c, midibyte_nr_c};

    logic       accept_p0;
    logic [7:0] data_byte;
    logic       timeout;

    dec_state_e state, state_n;
    logic [7:0] run_status, run_status_n;
    logic [6:0] d1_p1, d1_n;
    logic       sysex_n;

    logic       emit;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;
    msg_type_e  emit_type;
    logic       rt_hit;
    logic       chan_ok;

    midi_strobe_edge u_edge (
        .clk    (reg_clk),
        .strobe (byteready_c),
        .pulse  (accept_p0)
    );

    assign data_byte = midi_in_data_c;
    assign chan_ok   = OMNI || (run_status[3:0] == RX_CHANNEL);

    // ---- stage p0: classify accepted byte, next state ----
    always_comb begin
        state_n      = state;
        run_status_n = run_status;
        d1_n         = d1_p1;
        sysex_n      = sysex_active;
        emit         = 1'b0;
        emit_d1      = d1_p1;
        emit_d2      = 7'd0;
        rt_hit       = 1'b0;

        if (accept_p0) begin
            if (data_byte >= MIDI_RT_BASE) begin
                rt_hit = 1'b1;
            end else if (data_byte[7]) begin
                if (data_byte < MIDI_SYSEX_START) begin
                    run_status_n = data_byte;
                    state_n      = ST_WAIT_D1;
                    sysex_n      = 1'b0;
                end else if (data_byte == MIDI_SYSEX_START) begin
                    state_n = ST_SYSEX;
                    sysex_n = 1'b1;
                end else if (data_byte == MIDI_SYSEX_END) begin
                    sysex_n      = 1'b0;
                    state_n      = ST_IDLE;
                    run_status_n = 8'd0;
                end else begin
                    run_status_n = 8'd0;
                    state_n      = ST_DISCARD;
                end
            end else begin
                case (state)
                    ST_WAIT_D1: begin
                        if (midi_data_len(run_status) == 2'd1) begin
                            emit    = 1'b1;
                            emit_d1 = data_byte[6:0];
                        end else begin
                            d1_n    = data_byte[6:0];
                            state_n = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit    = 1'b1;
                        emit_d1 = d1_p1;
                        emit_d2 = data_byte[6:0];
                        state_n = ST_WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end

        if (timeout) begin
            state_n      = ST_IDLE;
            run_status_n = 8'd0;
        end
    end

    always_comb begin
        emit_type = MT_NONE;
        case (run_status[6:4])
            3'd0: emit_type = MT_NOTE_OFF;
            3'd1: emit_type = (emit_d2 == 7'd0) ? MT_NOTE_OFF : MT_NOTE_ON;
            3'd2: emit_type = MT_POLY_AT;
            3'd3: emit_type = MT_CC;
            3'd4: emit_type = MT_PROG;
            3'd5: emit_type = MT_CHAN_AT;
            3'd6: emit_type = MT_BEND;
            default: emit_type = MT_NONE;
        endcase
    end

    // ---- stage p1: state register ----
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            state      <= ST_IDLE;
            run_status <= 8'd0;
        end else begin
            state      <= state_n;
            run_status <= run_status_n;
        end
    end

    always_ff @(posedge reg_clk) begin
        d1_p1 <= d1_n;
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            msg_valid    <= 1'b0;
            msg_type     <= MT_NONE;
            msg_chan     <= 4'd0;
            msg_d1       <= 7'd0;
            msg_d2       <= 7'd0;
            rt_valid     <= 1'b0;
            rt_code      <= 3'd0;
            sysex_active <= 1'b0;
        end else begin
            msg_valid    <= emit & chan_ok;
            rt_valid     <= rt_hit;
            sysex_active <= sysex_n;
            // Filtered messages leave the previous fields untouched.
            if (emit && chan_ok) begin
                msg_type <= emit_type;
                msg_chan <= run_status[3:0];
                msg_d1   <= emit_d1;
                msg_d2   <= emit_d2;
            end
            if (rt_hit) begin
                rt_code <= data_byte[2:0];
            end
        end
    end

`ifdef MIDI_DEC_ACTSENSE_EN
    localparam int CNT_W = (ACTSENSE_TIMEOUT < 2) ? 1 : $clog2(ACTSENSE_TIMEOUT + 1);

    logic [CNT_W-1:0] as_cnt;
    logic             as_armed;
    logic             all_off_p1;

    // Any accepted byte reloads; only FE arms. Timeout only fires on a cycle
    // without a byte, since a byte in that cycle reloads the counter instead.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            as_armed   <= 1'b0;
            as_cnt     <= '0;
            all_off_p1 <= 1'b0;
        end else begin
            all_off_p1 <= 1'b0;
            if (accept_p0) begin
                as_cnt <= CNT_W'(ACTSENSE_TIMEOUT);
                if (data_byte == MIDI_ACTSENSE) begin
                    as_armed <= 1'b1;
                end
            end else if (as_armed) begin
                if (as_cnt == '0) begin
                    all_off_p1 <= 1'b1;
                    as_armed   <= 1'b0;
                end else begin
                    as_cnt <= as_cnt - 1'b1;
                end
            end
        end
    end

    assign timeout = as_armed & ~accept_p0 & (as_cnt == '0);
    assign all_off = all_off_p1;
`else
    localparam int unused_actsense = ACTSENSE_TIMEOUT;
    assign timeout = 1'b0;
    assign all_off = 1'b0;
`endif

endmodule

// File: tb/tb_midi_msg_decoder.sv
module tb_midi_msg_decoder;

    typedef struct packed {
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } msg_t;

    logic       clk = 1'b0;
    logic       reset_reg = 1'b1;
    logic       byteready_c = 1'b0;
    logic [7:0] midi_in_data_c = 8'd0;
    logic [7:0] cur_status_c = 8'd0;
    logic [7:0] midibyte_nr_c = 8'd0;

    logic       msg_valid, rt_valid, sysex_active, all_off;
    logic [2:0] msg_type, rt_code;
    logic [3:0] msg_chan;
    logic [6:0] msg_d1, msg_d2;

    logic       f_msg_valid, f_rt_valid, f_sysex_active, f_all_off;
    logic [2:0] f_msg_type, f_rt_code;
    logic [3:0] f_msg_chan;
    logic [6:0] f_msg_d1, f_msg_d2;

    int nchk = 0;
    int nfail = 0;

    msg_t       q[$];
    msg_t       qf[$];
    logic [2:0] rtq[$];
    int         all_off_cnt = 0;

    always #5 clk = ~clk;

    midi_msg_decoder #(.OMNI(1'b1), .RX_CHANNEL(4'd0), .ACTSENSE_TIMEOUT(100)) u_dut (
        .reg_clk(clk), .reset_reg(reset_reg), .byteready_c(byteready_c),
        .midi_in_data_c(midi_in_data_c), .cur_status_c(cur_status_c),
        .midibyte_nr_c(midibyte_nr_c), .msg_valid(msg_valid), .msg_type(msg_type),
        .msg_chan(msg_chan), .msg_d1(msg_d1), .msg_d2(msg_d2), .rt_valid(rt_valid),
        .rt_code(rt_code), .sysex_active(sysex_active), .all_off(all_off)
    );

    midi_msg_decoder #(.OMNI(1'b0), .RX_CHANNEL(4'd1), .ACTSENSE_TIMEOUT(100)) u_filt (
        .reg_clk(clk), .reset_reg(reset_reg), .byteready_c(byteready_c),
        .midi_in_data_c(midi_in_data_c), .cur_status_c(cur_status_c),
        .midibyte_nr_c(midibyte_nr_c), .msg_valid(f_msg_valid), .msg_type(f_msg_type),
        .msg_chan(f_msg_chan), .msg_d1(f_msg_d1), .msg_d2(f_msg_d2), .rt_valid(f_rt_valid),
        .rt_code(f_rt_code), .sysex_active(f_sysex_active), .all_off(f_all_off)
    );

    always @(negedge clk) begin
        if (msg_valid === 1'b1) q.push_back({msg_type, msg_chan, msg_d1, msg_d2});
        if (f_msg_valid === 1'b1) qf.push_back({f_msg_type, f_msg_chan, f_msg_d1, f_msg_d2});
        if (rt_valid === 1'b1) rtq.push_back(rt_code);
        if (all_off === 1'b1) all_off_cnt = all_off_cnt + 1;
    end

    function automatic msg_t msg_at(input int idx);
        msg_t m;
        m = '0;
        if (idx < q.size()) m = q[idx];
        return m;
    endfunction

    // Drives one byte for 'hold' cycles, then one low cycle. vld_next is
    // msg_valid in the cycle after the accept cycle.
    task automatic send_byte(input logic [7:0] b, input int hold, output logic vld_next);
        byteready_c = 1'b1;
        midi_in_data_c = b;
        midibyte_nr_c = midibyte_nr_c + 8'd1;
        if (b[7]) cur_status_c = b;
        @(posedge clk); #1;
        vld_next = msg_valid;
        repeat (hold - 1) begin
            @(posedge clk); #1;
        end
        byteready_c = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic v;
        send_byte(b, 1, v);
    endtask

    task automatic test_reset;
        int base;
        reset_reg = 1'b1;
        byteready_c = 1'b1;
        midi_in_data_c = 8'h90;
        repeat (2) begin
            @(posedge clk); #1;
        end
        nchk++; if (msg_valid !== 1'b0) begin nfail++; $display("FAIL reset_msg_valid got %b want 0", msg_valid); end
        nchk++; if (msg_type !== 3'd0) begin nfail++; $display("FAIL reset_msg_type got %0d want 0", msg_type); end
        nchk++; if ({msg_chan, msg_d1, msg_d2} !== 18'd0) begin nfail++; $display("FAIL reset_fields got %h/%h/%h want 0", msg_chan, msg_d1, msg_d2); end
        nchk++; if ({rt_valid, rt_code, sysex_active, all_off} !== 6'd0) begin nfail++; $display("FAIL reset_rt_sysex got %b%b%b%b want 0", rt_valid, rt_code, sysex_active, all_off); end
        reset_reg = 1'b0;
        @(posedge clk); #1;
        byteready_c = 1'b0;
        @(posedge clk); #1;
        base = q.size();
        send(8'h3C); send(8'h64);
        nchk++; if (q.size() - base !== 0) begin nfail++; $display("FAIL reset_wins_edge got %0d msgs want 0", q.size() - base); end
    endtask

    task automatic test_note_on;
        int base;
        logic v1, v2, v3;
        base = q.size();
        send_byte(8'h90, 1, v1);
        send_byte(8'h3C, 1, v2);
        send_byte(8'h64, 1, v3);
        nchk++; if ({v1, v2, v3} !== 3'b001) begin nfail++; $display("FAIL note_on_latency got %b want 001", {v1, v2, v3}); end
        nchk++; if (q.size() - base !== 1) begin nfail++; $display("FAIL note_on_count got %0d want 1", q.size() - base); end
        nchk++; if (msg_at(base) !== {3'd2, 4'd0, 7'h3C, 7'h64}) begin nfail++; $display("FAIL note_on_msg got %h want %h", msg_at(base), {3'd2, 4'd0, 7'h3C, 7'h64}); end
    endtask

    task automatic test_running_status;
        int base;
        base = q.size();
        send(8'h93); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00);
        nchk++; if (q.size() - base !== 2) begin nfail++; $display("FAIL running_count got %0d want 2", q.size() - base); end
        nchk++; if (msg_at(base) !== {3'd2, 4'd3, 7'h3C, 7'h64}) begin nfail++; $display("FAIL running_msg0 got %h want %h", msg_at(base), {3'd2, 4'd3, 7'h3C, 7'h64}); end
        nchk++; if (msg_at(base + 1) !== {3'd1, 4'd3, 7'h3E, 7'h00}) begin nfail++; $display("FAIL running_msg1 got %h want %h", msg_at(base + 1), {3'd1, 4'd3, 7'h3E, 7'h00}); end
    endtask

    task automatic test_prog_hold;
        int base;
        logic v;
        base = q.size();
        send_byte(8'hC5, 3, v);
        send_byte(8'h07, 3, v);
        send_byte(8'h08, 3, v);
        nchk++; if (q.size() - base !== 2) begin nfail++; $display("FAIL prog_hold_count got %0d want 2", q.size() - base); end
        nchk++; if (msg_at(base) !== {3'd5, 4'd5, 7'h07, 7'h00}) begin nfail++; $display("FAIL prog_msg0 got %h want %h", msg_at(base), {3'd5, 4'd5, 7'h07, 7'h00}); end
        nchk++; if (msg_at(base + 1) !== {3'd5, 4'd5, 7'h08, 7'h00}) begin nfail++; $display("FAIL prog_msg1 got %h want %h", msg_at(base + 1), {3'd5, 4'd5, 7'h08, 7'h00}); end
    endtask

    task automatic test_realtime;
        int base, rbase;
        base = q.size();
        rbase = rtq.size();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h40); send(8'hFA);
        nchk++; if (rtq.size() - rbase !== 2) begin nfail++; $display("FAIL rt_count got %0d want 2", rtq.size() - rbase); end
        nchk++; if (rtq.size() - rbase == 2 && {rtq[rbase], rtq[rbase + 1]} !== 6'b000_010) begin nfail++; $display("FAIL rt_codes got %0d,%0d want 0,2", rtq[rbase], rtq[rbase + 1]); end
        nchk++; if (rt_code !== 3'd2) begin nfail++; $display("FAIL rt_code_hold got %0d want 2", rt_code); end
        nchk++; if (q.size() - base !== 1) begin nfail++; $display("FAIL rt_msg_count got %0d want 1", q.size() - base); end
        nchk++; if (msg_at(base) !== {3'd2, 4'd0, 7'h3C, 7'h40}) begin nfail++; $display("FAIL rt_msg got %h want %h", msg_at(base), {3'd2, 4'd0, 7'h3C, 7'h40}); end
    endtask

    task automatic test_sysex_filter;
        int base, fbase;
        logic [2:0] sx;
        base = q.size();
        fbase = qf.size();
        send(8'hF0);
        sx[2] = sysex_active;
        send(8'h7E);
        sx[1] = sysex_active;
        send(8'h01);
        sx[0] = sysex_active;
        nchk++; if (sx !== 3'b111) begin nfail++; $display("FAIL sysex_active_high got %b want 111", sx); end
        nchk++; if (q.size() - base !== 0) begin nfail++; $display("FAIL sysex_no_msg got %0d want 0", q.size() - base); end
        send(8'hF7);
        nchk++; if (sysex_active !== 1'b0) begin nfail++; $display("FAIL sysex_end got %b want 0", sysex_active); end
        send(8'h90); send(8'h40); send(8'h40);
        nchk++; if (q.size() - base !== 1 || msg_at(base) !== {3'd2, 4'd0, 7'h40, 7'h40}) begin nfail++; $display("FAIL sysex_after_msg got %0d/%h want 1/%h", q.size() - base, msg_at(base), {3'd2, 4'd0, 7'h40, 7'h40}); end
        nchk++; if (qf.size() - fbase !== 0) begin nfail++; $display("FAIL filter_ch0_suppressed got %0d want 0", qf.size() - fbase); end
        send(8'h91); send(8'h40); send(8'h40);
        nchk++; if (qf.size() - fbase !== 1) begin nfail++; $display("FAIL filter_ch1_count got %0d want 1", qf.size() - fbase); end
        nchk++; if (qf.size() - fbase == 1 && qf[fbase] !== {3'd2, 4'd1, 7'h40, 7'h40}) begin nfail++; $display("FAIL filter_ch1_msg got %h want %h", qf[fbase], {3'd2, 4'd1, 7'h40, 7'h40}); end
    endtask

    task automatic test_status_abort;
        int base;
        base = q.size();
        send(8'h90); send(8'h3C);
        send(8'hB2); send(8'h07); send(8'h05);
        nchk++; if (q.size() - base !== 1 || msg_at(base) !== {3'd4, 4'd2, 7'h07, 7'h05}) begin nfail++; $display("FAIL abort_cc got %0d/%h want 1/%h", q.size() - base, msg_at(base), {3'd4, 4'd2, 7'h07, 7'h05}); end
        send(8'hF0); send(8'h11); send(8'hE1);
        nchk++; if (sysex_active !== 1'b0) begin nfail++; $display("FAIL sysex_abort got %b want 0", sysex_active); end
        send(8'h00); send(8'h40);
        nchk++; if (msg_at(base + 1) !== {3'd7, 4'd1, 7'h00, 7'h40}) begin nfail++; $display("FAIL bend_msg got %h want %h", msg_at(base + 1), {3'd7, 4'd1, 7'h00, 7'h40}); end
        send(8'hA0); send(8'h10); send(8'hF3); send(8'h20);
        nchk++; if (q.size() - base !== 2) begin nfail++; $display("FAIL discard_count got %0d want 2", q.size() - base); end
        send(8'hA0); send(8'h10); send(8'h20); send(8'hF8);
        nchk++; if ({msg_type, msg_chan, msg_d1, msg_d2} !== {3'd3, 4'd0, 7'h10, 7'h20}) begin nfail++; $display("FAIL poly_hold got %h want %h", {msg_type, msg_chan, msg_d1, msg_d2}, {3'd3, 4'd0, 7'h10, 7'h20}); end
    endtask

    task automatic test_reset_partial;
        int base;
        base = q.size();
        send(8'hB0); send(8'h07);
        reset_reg = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_reg = 1'b0;
        nchk++; if (msg_type !== 3'd0) begin nfail++; $display("FAIL partial_reset_type got %0d want 0", msg_type); end
        send(8'h10);
        nchk++; if (q.size() - base !== 0) begin nfail++; $display("FAIL partial_discard got %0d want 0", q.size() - base); end
    endtask

    task automatic test_actsense;
        int a0, base;
        a0 = all_off_cnt;
        base = q.size();
`ifdef MIDI_DEC_ACTSENSE_EN
        send(8'h90);
        send(8'hFE);
        repeat (120) begin
            @(posedge clk); #1;
        end
        nchk++; if (all_off_cnt - a0 !== 1) begin nfail++; $display("FAIL actsense_pulses got %0d want 1", all_off_cnt - a0); end
        send(8'h3C); send(8'h40);
        nchk++; if (q.size() - base !== 0) begin nfail++; $display("FAIL actsense_idle got %0d want 0", q.size() - base); end
`else
        send(8'hFE);
        repeat (120) begin
            @(posedge clk); #1;
        end
        nchk++; if (all_off_cnt - a0 !== 0 || all_off !== 1'b0) begin nfail++; $display("FAIL all_off_tied got %0d/%b want 0/0", all_off_cnt - a0, all_off); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_note_on();
        test_running_status();
        test_prog_hold();
        test_realtime();
        test_sysex_filter();
        test_status_abort();
        test_reset_partial();
        test_actsense();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/midi_msg_decoder.md
Name: midi_msg_decoder

Overview:
Sits directly downstream of the CPU MIDI byte port. It consumes the byte strobe, the current data byte and the logged status byte, and assembles complete channel-voice messages. Each message is emitted as a single-cycle valid pulse with type, channel and two 7-bit data fields for the voice allocator. Running status, SysEx skipping and interleaved real-time bytes are handled here, so downstream logic sees only whole messages.

Parameters:
OMNI, 1, 1 = accept all channels; 0 = accept only RX_CHANNEL
RX_CHANNEL, 0, 4-bit channel accepted when OMNI=0
ACTSENSE_TIMEOUT, 15000000, reg_clk cycles without any byte before active-sense timeout (used only with the optional feature)

Ports:
reg_clk  in  1  system register clock; the only clock
reset_reg  in  1  synchronous, active-high reset
byteready_c  in  1  byte strobe from the upstream port; may stay high for 1-3 cycles per byte
midi_in_data_c  in  8  current MIDI byte; stable while byteready_c is high
cur_status_c  in  8  last logged status byte (informational; the decoder keeps its own status)
midibyte_nr_c  in  8  upstream byte counter (informational; not used for decode)
msg_valid  out  1  one-cycle pulse: a message is on msg_*
msg_type  out  3  msg_type_e from the package
msg_chan  out  4  MIDI channel 0-15
msg_d1  out  7  first data byte (note, controller number, program, pressure, bend LSB)
msg_d2  out  7  second data byte (velocity, value, bend MSB); 0 for two-byte messages
rt_valid  out  1  one-cycle pulse for a real-time byte (F8-FF)
rt_code  out  3  low 3 bits of the real-time byte
sysex_active  out  1  high between F0 and F7
all_off  out  1  one-cycle pulse on active-sense timeout (feature only; else tied 0)

Behaviour:
- Byte accept: exactly one byte per rising edge of byteready_c, detected with a registered copy of the strobe. The byte is sampled from midi_in_data_c in the edge cycle. Repeated high cycles are ignored.
- Latency: msg_valid and rt_valid assert in the cycle after the accept cycle. msg_* fields hold until the next msg_valid.
- Reset (sync, active high): state=IDLE; run_status=0; msg_valid=0; rt_valid=0; msg_type=MT_NONE; msg_chan=0; msg_d1=0; msg_d2=0; rt_code=0; sysex_active=0; all_off=0. Reset wins over a simultaneous byte edge. A partial message is discarded.
- Real-time bytes (F8-FF): pulse rt_valid and set rt_code, in any state. State, run_status, the data counter and sysex_active are untouched.
- FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX, DISCARD.
- Status 80-EF: latch run_status and go to WAIT_D1, from any state. Reaching it from WAIT_D2 drops the incomplete message. Reaching it from SYSEX also clears sysex_active (unterminated SysEx is aborted).
- Status F0: go to SYSEX; sysex_active=1.
- Status F7: sysex_active=0; go to IDLE; run_status=0.
- Status F1-F6: run_status=0; go to DISCARD.
- Data bytes (bit 7 = 0):
  - In IDLE or DISCARD: ignored.
  - In SYSEX: ignored.
  - In WAIT_D1, for Cx/Dx: emit msg_valid with d2=0 and stay in WAIT_D1 (running status).
  - In WAIT_D1, for other statuses: latch d1 and go to WAIT_D2.
  - In WAIT_D2: emit msg_valid and return to WAIT_D1 (running status).
- Type mapping:
  - 8x = MT_NOTE_OFF.
  - 9x with velocity 0 = MT_NOTE_OFF; 9x otherwise = MT_NOTE_ON.
  - Ax = MT_POLY_AT; Bx = MT_CC; Cx = MT_PROG; Dx = MT_CHAN_AT; Ex = MT_BEND.
- Channel filter: when OMNI=0 and the channel differs from RX_CHANNEL, msg_valid is suppressed. FSM progression and running status continue unchanged.

Optional Feature:
- Macro MIDI_DEC_ACTSENSE_EN.
- With the macro defined:
  - An FE byte arms a counter.
  - Every accepted byte, including real-time bytes, reloads the counter to ACTSENSE_TIMEOUT.
  - When the counter reaches 0 while armed: pulse all_off for one cycle, disarm, state=IDLE, run_status=0.
- Without the macro: no counter is built and all_off is constant 0.

Decomposition:
- Package midi_pkg:
  - msg_type_e (3-bit: MT_NONE, MT_NOTE_OFF, MT_NOTE_ON, MT_POLY_AT, MT_CC, MT_PROG, MT_CHAN_AT, MT_BEND).
  - Constants MIDI_SYSEX_START=8'hF0, MIDI_SYSEX_END=8'hF7, MIDI_RT_BASE=8'hF8, MIDI_ACTSENSE=8'hFE.
  - Function midi_data_len(status) returning 1 or 2.
- Sub-module midi_strobe_edge (registered rising-edge detect on byteready_c, producing the one-cycle accept pulse). It is reused by other byte consumers.

Test Plan:
- 90 3C 64 -> one msg_valid: NOTE_ON, chan 0, d1=0x3C, d2=0x64, one cycle after the third accept.
- 93 3C 64 3E 00 (running status) -> two messages: NOTE_ON ch3 3C/64, then NOTE_OFF ch3 3E/00.
- C5 07 08 -> two PROG messages on ch5, d1=07 then 08, d2=0; byteready_c held 3 cycles per byte produces no duplicates.
- 90 3C F8 40 -> rt_valid with rt_code=0, then NOTE_ON 3C/40; no message corruption.
- F0 7E 01 F7 90 40 40 -> sysex_active high over 7E 01, no msg_valid during SysEx, then NOTE_ON 40/40; OMNI=0, RX_CHANNEL=1 -> the same NOTE_ON on ch0 is suppressed.
- reset_reg asserted after B0 07 -> then 10 alone produces no message; with MIDI_DEC_ACTSENSE_EN, ACTSENSE_TIMEOUT=100: FE followed by 100 idle cycles -> all_off pulses once.
